heat_cycle_controller: RTL

Sequences the water-heating phase of a wash program.
- Accepts a program request with a temperature class and drives start/target to the temperature unit.
- Waits for its ready flag, with per-attempt timeout and bounded retries, then runs a timed soak.
- Reports done or fault to the main wash sequencer. Sits between the wash-program FSM and the temperature unit.

---
 rtl/heat_cycle_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/heat_cycle_controller.sv
// Heating-phase sequencer between the wash-program FSM and the temperature unit.
// Define HEAT_STATS_EN to add the heat_cycles statistics output.
module heat_cycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned SOAK_CYCLES    = 16,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cycle_req,
    input  logic [1:0]  cycle_temp,
    input  logic        abort,
    input  logic        heat_ready,
    output logic        heat_start,
    output logic [3:0]  heat_target,
    output logic        busy,
    output logic        cycle_done,
    output logic        fault,
`ifdef HEAT_STATS_EN
    output logic [15:0] heat_cycles,
`endif
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        RETRY = 3'd2,
        SOAK  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   HEAT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SOAK_LAST  = CNT_W'(SOAK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RETRY_LAST = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [1:0]         r_class;
    logic [1:0]         w_class_nxt;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && cycle_req && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_class     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_class     <= w_class_nxt;
        end
    end

    // One shared timer serves HEAT, RETRY and SOAK; each entry clears it.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry_cnt;
        w_class_nxt = r_class;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cycle_req) begin
                        w_class_nxt = cycle_temp;
                        w_timer_nxt = '0;
                        w_retry_nxt = '0;
                        w_state_nxt = (cycle_temp == 2'd0) ? SOAK : HEAT;
                    end
                end
                HEAT: begin
                    if (heat_ready) begin
                        w_state_nxt = SOAK;
                        w_timer_nxt = '0;
                    end else if (r_timer == HEAT_LAST) begin
                        w_timer_nxt = '0;
                        if (r_retry_cnt < RETRY_MAX) begin
                            w_state_nxt = RETRY;
                            w_retry_nxt = r_retry_cnt + RETRY_W'(1);
                        end else begin
                            w_state_nxt = FAULT;
                        end
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                RETRY: begin
                    if (r_timer == RETRY_LAST) begin
                        w_state_nxt = HEAT;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                SOAK: begin
                    if (r_timer == SOAK_LAST) begin
                        w_state_nxt = DONE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                DONE:    w_state_nxt = IDLE;
                FAULT:   w_state_nxt = FAULT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign heat_start  = (r_state == HEAT) || ((r_state == SOAK) && (r_class != 2'd0));
    assign heat_target = {r_class, 2'b00};
    assign busy        = (r_state != IDLE);
    assign cycle_done  = (r_state == DONE);
    assign fault       = (r_state == FAULT);
    assign state_out   = r_state;

`ifdef HEAT_STATS_EN
    logic [15:0] r_heat_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_heat_cycles <= '0;
        end else if (w_accept) begin
            r_heat_cycles <= '0;
        end else if ((r_state == HEAT) && (r_heat_cycles != '1)) begin
            r_heat_cycles <= r_heat_cycles + 16'd1;
        end
    end

    assign heat_cycles = r_heat_cycles;
`endif

endmodule
